// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage program-counter logic.
// Imported by the next-PC mux and by the fetch stage top.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } fetch_state_e;

    // Which source the next PC is taken from.
    typedef enum logic [1:0] {
        SEL_HOLD     = 2'd0,
        SEL_INC      = 2'd1,
        SEL_REDIRECT = 2'd2,
        SEL_PENDING  = 2'd3
    } next_sel_e;

    localparam logic [31:0] PC_ALIGN_MASK        = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: increment, redirect, buffered redirect or hold.
// Also word-aligns the raw redirect target and reports whether it was misaligned.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [1:0]          sel,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] pc_add_result,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic [PC_WIDTH-1:0] pending_target,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic [PC_WIDTH-1:0] aligned_target,
    output logic                target_misaligned
);

    // Only the two low bits are ever cleared, whatever the PC width.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, PC_ALIGN_MASK[1:0]};

    assign aligned_target    = redirect_target & ALIGN_MASK;
    assign target_misaligned = |redirect_target[1:0];

    always_comb begin
        next_pc = pc;
        case (next_sel_e'(sel))
            SEL_HOLD:     next_pc = pc;
            SEL_INC:      next_pc = pc_add_result;
            SEL_REDIRECT: next_pc = aligned_target;
            SEL_PENDING:  next_pc = pending_target;
            default:      next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// IF-stage program counter: holds the PC, selects the next PC each cycle and
// buffers a redirect that arrives while the pipeline is stalled.
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter int                   PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic [PC_WIDTH-1:0] pc_add_result,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_valid,
    output logic                redirect_pending,
    output logic                misaligned
);

    // redirect_valid is a single-cycle pulse with no ready: it is always
    // consumed at the edge it is seen (outside BOOT), either applied to pc or
    // buffered when stall is high. A newer redirect replaces a buffered one.

    fetch_state_e        state;
    fetch_state_e        state_next;
    next_sel_e           sel;
    logic                pend_load;
    logic [PC_WIDTH-1:0] pending_target;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] aligned_target;
    logic                target_misaligned;
    logic                accept_redirect;

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_sel (
        .sel               (sel),
        .pc                (pc),
        .pc_add_result     (pc_add_result),
        .redirect_target   (redirect_target),
        .pending_target    (pending_target),
        .next_pc           (next_pc),
        .aligned_target    (aligned_target),
        .target_misaligned (target_misaligned)
    );

    always_comb begin
        state_next      = state;
        sel             = SEL_HOLD;
        pend_load       = 1'b0;
        accept_redirect = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                accept_redirect = redirect_valid;
                if (redirect_valid && !stall) begin
                    sel = SEL_REDIRECT;
                end else if (redirect_valid) begin
                    pend_load  = 1'b1;
                    state_next = ST_PEND;
                end else if (!stall) begin
                    sel = SEL_INC;
                end
            end
            ST_PEND: begin
                accept_redirect = redirect_valid;
                pend_load       = redirect_valid;
                if (!stall) begin
                    sel        = redirect_valid ? SEL_REDIRECT : SEL_PENDING;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_BOOT;
            pc               <= RESET_VECTOR;
            fetch_valid      <= 1'b0;
            redirect_pending <= 1'b0;
            pending_target   <= '0;
            misaligned       <= 1'b0;
        end else begin
            state            <= state_next;
            pc               <= next_pc;
            fetch_valid      <= (state_next != ST_BOOT);
            redirect_pending <= (state_next == ST_PEND);
            if (pend_load) begin
                pending_target <= aligned_target;
            end
            if (accept_redirect && target_misaligned) begin
                misaligned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus a randomized
// run scored against a behavioural next-PC model.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_add_result;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        misaligned;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic        m_mis;

    logic [31:0] exp_q[$];

    pc_fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .pc_add_result    (pc_add_result),
        .pc               (pc),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .misaligned       (misaligned)
    );

    // Incrementor outside the DUT
    assign pc_add_result = pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then advance the model by the same edge.
    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] t);
        logic [31:0] a;
        @(negedge clk);
        rst             = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        @(posedge clk);
        #1;
        a = {t[31:2], 2'b00};
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0; m_mis = 1'b0;
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else begin
            if (rv && t[1:0] != 2'b00) m_mis = 1'b1;
            if (m_pend) begin
                if (rv) m_ptgt = a;
                if (!s) begin
                    m_pc   = m_ptgt;
                    m_pend = 1'b0;
                end
            end else if (rv && !s) begin
                m_pc = a;
            end else if (rv) begin
                m_ptgt = a;
                m_pend = 1'b1;
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h0 || fetch_valid !== 1'b0 || redirect_pending !== 1'b0 || misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h fv=%b rp=%b mis=%b, required pc=0 fv=0 rp=0 mis=0",
                     pc, fetch_valid, redirect_pending, misaligned);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if (pc !== exp_seq[i] || fetch_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL boot_seq[%0d]: pc=%h fv=%b, required pc=%h fv=1", i, pc, fetch_valid, exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_setup: pc=%h, required 00000010", pc);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            n_cmp++;
            if (pc !== 32'h10 || fetch_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h fv=%b, required pc=00000010 fv=1", i, pc, fetch_valid);
            end
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h14) begin
            n_fail++;
            $display("FAIL stall_release: pc=%h, required 00000014", pc);
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h20) begin
            n_fail++;
            $display("FAIL redirect_setup: pc=%h, required 00000020", pc);
        end
        step(0, 0, 1, 32'h400);
        n_cmp++;
        if (pc !== 32'h400 || redirect_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_take: pc=%h rp=%b, required pc=00000400 rp=0", pc, redirect_pending);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h404) begin
            n_fail++;
            $display("FAIL redirect_next: pc=%h, required 00000404", pc);
        end
    endtask

    task automatic test_redirect_under_stall();
        step(0, 1, 1, 32'h800);
        n_cmp++;
        if (pc !== 32'h404 || redirect_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_first: pc=%h rp=%b, required pc=00000404 rp=1", pc, redirect_pending);
        end
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h900);
        n_cmp++;
        if (pc !== 32'h404 || redirect_pending !== 1'b1 || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_overwrite: pc=%h rp=%b fv=%b, required pc=00000404 rp=1 fv=1",
                     pc, redirect_pending, fetch_valid);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h900 || redirect_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_release: pc=%h rp=%b, required pc=00000900 rp=0", pc, redirect_pending);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h904) begin
            n_fail++;
            $display("FAIL pend_after: pc=%h, required 00000904", pc);
        end
    endtask

    task automatic test_misaligned();
        n_cmp++;
        if (misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_before: mis=%b, required 0", misaligned);
        end
        step(0, 0, 1, 32'h102);
        n_cmp++;
        if (pc !== 32'h100 || misaligned !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_take: pc=%h mis=%b, required pc=00000100 mis=1", pc, misaligned);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if (misaligned !== 1'b1 || pc !== 32'h100 + 32'(4 * (i + 1))) begin
                n_fail++;
                $display("FAIL mis_sticky[%0d]: pc=%h mis=%b, required pc=%h mis=1",
                         i, pc, misaligned, 32'h100 + 32'(4 * (i + 1)));
            end
        end
        step(1, 0, 0, 0);
        n_cmp++;
        if (misaligned !== 1'b0 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL mis_reset: pc=%h mis=%b, required pc=0 mis=0", pc, misaligned);
        end
    endtask

    task automatic test_wrap_reset();
        step(0, 1, 1, 32'h555);
        n_cmp++;
        if (fetch_valid !== 1'b1 || pc !== 32'h0 || redirect_pending !== 1'b0 || misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_ignore: pc=%h fv=%b rp=%b mis=%b, required pc=0 fv=1 rp=0 mis=0",
                     pc, fetch_valid, redirect_pending, misaligned);
        end
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: pc=%h, required 00000000", pc);
        end
        step(0, 1, 1, 32'h1230);
        step(1, 1, 0, 0);
        n_cmp++;
        if (redirect_pending !== 1'b0 || pc !== 32'h0 || fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_reset: pc=%h fv=%b rp=%b, required pc=0 fv=0 rp=0",
                     pc, fetch_valid, redirect_pending);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++;
        if (pc !== 32'h4) begin
            n_fail++;
            $display("FAIL no_stale_redirect: pc=%h, required 00000004", pc);
        end
    endtask

    task automatic test_random();
        logic        r, s, rv;
        logic [31:0] t;
        logic [31:0] exp_pc;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 3) == 0);
            t  = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            step(r, s, rv, t);
            exp_q.push_back(m_pc);
            exp_pc = exp_q.pop_front();
            n_cmp++;
            if (pc !== exp_pc || fetch_valid !== m_valid || redirect_pending !== m_pend || misaligned !== m_mis) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h fv=%b rp=%b mis=%b, required pc=%h fv=%b rp=%b mis=%b",
                         i, pc, fetch_valid, redirect_pending, misaligned, exp_pc, m_valid, m_pend, m_mis);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        m_pc = 32'h0; m_valid = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0; m_mis = 1'b0;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_under_stall();
        test_misaligned();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
